// File: rtl/sram_ctrl.sv
// sram_ctrl: sequencer for the SRAM macro (write driver, cell array, sense amp).
// Takes single-word read/write requests on a valid/ready handshake and produces
// wordline, write-driver, precharge and sense-amp timing. Each request ends
// with a one-cycle response pulse.
module sram_ctrl #(
  parameter int unsigned ROWS    = 2,
  parameter int unsigned COLS    = 8,
  parameter int unsigned ADDR_W  = 1,
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned WL_CYC  = 10,
  parameter int unsigned REC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [COLS-1:0]   rsp_rdata,
  output logic [ROWS-1:0]   row_wr,
  output logic [ROWS-1:0]   row_rd,
  output logic [COLS-1:0]   wr_data,
  output logic              wr_en,
  output logic              pre_en,
  output logic              sa_en,
  input  logic [COLS-1:0]   sa_data
);

  localparam int unsigned MAX_PW  = (WL_CYC > REC_CYC) ? WL_CYC : REC_CYC;
  localparam int unsigned MAX_CYC = (PRE_CYC > MAX_PW) ? PRE_CYC : MAX_PW;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    PRE      = 3'd3,
    RD_PULSE = 3'd4,
    SENSE    = 3'd5,
    RECOVER  = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLS-1:0]     wdata_q, wdata_d;
  logic [COLS-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                addr_oor;
  logic                cnt_last;
  logic [ROWS-1:0]     row_sel;

  // Request address beyond the array, and end-of-phase detect for the down-counter.
  always_comb begin
    addr_oor = (32'(req_addr) >= ROWS);
    cnt_last = (cnt_q == CNT_W'(1));
  end

  // One-hot decode of the captured row address.
  always_comb begin
    row_sel = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_sel[r] = (32'(addr_q) == r);
    end
  end

  // State register and captured request / response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, phase counter and data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = addr_oor;
          if (addr_oor) begin
            state_d = DONE;
          end else if (req_we) begin
            state_d = WR_SETUP;
          end else begin
            state_d = PRE;
            cnt_d   = CNT_W'(PRE_CYC);
          end
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(WL_CYC);
      end
      WR_PULSE: begin
        if (cnt_last) begin
          state_d = RECOVER;
          cnt_d   = CNT_W'(REC_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PRE: begin
        if (cnt_last) begin
          state_d = RD_PULSE;
          cnt_d   = CNT_W'(WL_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_PULSE: begin
        if (cnt_last) begin
          state_d = SENSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SENSE: begin
        rdata_d = sa_data;
        state_d = RECOVER;
        cnt_d   = CNT_W'(REC_CYC);
      end
      RECOVER: begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Macro controls and response decoded from the registered state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = rdata_q;
    row_wr    = '0;
    row_rd    = '0;
    wr_data   = '0;
    wr_en     = 1'b0;
    pre_en    = 1'b0;
    sa_en     = 1'b0;

    unique case (state_q)
      IDLE:     req_ready = 1'b1;
      WR_SETUP: begin
        wr_data = wdata_q;
        wr_en   = 1'b1;
      end
      WR_PULSE: begin
        wr_data = wdata_q;
        wr_en   = 1'b1;
        row_wr  = row_sel;
      end
      PRE:      pre_en = 1'b1;
      RD_PULSE: row_rd = row_sel;
      SENSE: begin
        row_rd = row_sel;
        sa_en  = 1'b1;
      end
      RECOVER:  ;
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors for sram_ctrl (ROWS=2, ADDR_W=2 so an
// out-of-range address can be issued). Outputs sampled 1ns after rising edge.
module tb_sram_ctrl;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 8;
  localparam int unsigned AW   = 2;
  localparam int PRE = 2;
  localparam int WL  = 10;
  localparam int REC = 2;
  localparam int WR_TOTAL = 2 + WL + REC;        // 14
  localparam int RD_TOTAL = PRE + WL + REC + 2;  // 16

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic [ROWS-1:0] row_wr;
  logic [ROWS-1:0] row_rd;
  logic [COLS-1:0] wr_data;
  logic            wr_en;
  logic            pre_en;
  logic            sa_en;
  logic [COLS-1:0] sa_data;

  int n_chk  = 0;
  int n_pass = 0;

  sram_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(AW),
    .PRE_CYC(PRE), .WL_CYC(WL), .REC_CYC(REC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .row_wr(row_wr), .row_rd(row_rd), .wr_data(wr_data), .wr_en(wr_en),
    .pre_en(pre_en), .sa_en(sa_en), .sa_data(sa_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] status();
    return {req_ready, rsp_valid, rsp_err, wr_en, pre_en, sa_en, row_wr, row_rd};
  endfunction

  // Expected {ready,valid,err,wr_en,pre_en,sa_en,row_wr,row_rd} in cycle k after accept.
  function automatic logic [9:0] exp_status(input logic we, input logic oor,
                                            input logic [AW-1:0] addr, input int k);
    logic [1:0] oh;
    oh = (addr == 2'd0) ? 2'b01 : 2'b10;
    if (oor) return (k == 1) ? 10'b0110000000 : 10'b1000000000;
    if (we) begin
      if (k == 1)             return 10'b0001000000;
      if (k <= 1 + WL)        return {6'b000100, oh, 2'b00};
      if (k <= 1 + WL + REC)  return 10'b0;
      if (k == WR_TOTAL)      return 10'b0100000000;
      return 10'b1000000000;
    end
    if (k <= PRE)             return 10'b0000100000;
    if (k <= PRE + WL)        return {8'b00000000, oh};
    if (k == PRE + WL + 1)    return {8'b00000100, oh};
    if (k <= PRE + WL + 1 + REC) return 10'b0;
    if (k == RD_TOTAL)        return 10'b0100000000;
    return 10'b1000000000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ready, present a request, step through the accept edge.
  task automatic start_op(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] d);
    int guard;
    guard = 0;
    while (!req_ready && guard < 40) begin
      step();
      guard++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Check cycles 1..nk after accept (caller is already in cycle 1).
  task automatic check_op(input string tag, input logic we, input logic oor,
                          input logic [AW-1:0] addr, input logic [COLS-1:0] d,
                          input logic [COLS-1:0] exp_rd, input int nk);
    for (int k = 1; k <= nk; k++) begin
      chk($sformatf("%s_st_k%0d", tag, k), 32'(status()), 32'(exp_status(we, oor, addr, k)));
      if (we && !oor && k <= 1 + WL) chk($sformatf("%s_wd_k%0d", tag, k), 32'(wr_data), 32'(d));
      if (!we && !oor && k == RD_TOTAL) chk($sformatf("%s_rdata", tag), 32'(rsp_rdata), 32'(exp_rd));
      if (oor && k == 1) chk($sformatf("%s_rdata_keep", tag), 32'(rsp_rdata), 32'(exp_rd));
      if (k < nk) step();
    end
  endtask

  initial begin
    int vcount;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; sa_data = '0;

    // Reset held three cycles
    repeat (3) step();
    chk("reset_status", 32'(status()), 32'(10'b1000000000));
    chk("reset_rdata", 32'(rsp_rdata), 32'h0);
    rst = 1'b0;
    step();

    // Write addr=1 data=A5
    start_op(1'b1, 2'd1, 8'hA5);
    check_op("wr1", 1'b1, 1'b0, 2'd1, 8'hA5, 8'h00, WR_TOTAL + 1);
    chk("wr1_rdata_keep", 32'(rsp_rdata), 32'h0);

    // Read addr=0, sense amp returns 3C
    sa_data = 8'h3C;
    start_op(1'b0, 2'd0, 8'h00);
    check_op("rd0", 1'b0, 1'b0, 2'd0, 8'h00, 8'h3C, RD_TOTAL + 1);

    // Back-to-back: write addr0 5A, then read addr1 with valid held high
    sa_data = 8'hC3;
    req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'h5A; req_valid = 1'b1;
    step();
    req_we = 1'b0; req_addr = 2'd1; req_wdata = 8'hFF;
    check_op("b2b_wr", 1'b1, 1'b0, 2'd0, 8'h5A, 8'h00, WR_TOTAL + 1);
    step();
    req_valid = 1'b0;
    check_op("b2b_rd", 1'b0, 1'b0, 2'd1, 8'h00, 8'hC3, RD_TOTAL + 1);

    // Out-of-range address 3: immediate error response, read data untouched
    sa_data = 8'h77;
    start_op(1'b0, 2'd3, 8'h00);
    check_op("oor", 1'b0, 1'b1, 2'd3, 8'h00, 8'hC3, 2);
    chk("oor_rdata_after", 32'(rsp_rdata), 32'hC3);

    // Reset during RD_PULSE aborts the read
    start_op(1'b0, 2'd1, 8'h00);
    repeat (4) step();
    chk("abort_pre_status", 32'(status()), 32'(exp_status(1'b0, 1'b0, 2'd1, 5)));
    rst = 1'b1;
    step();
    chk("abort_status", 32'(status()), 32'(10'b1000000000));
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid) vcount++;
    end
    chk("abort_no_rsp", 32'(vcount), 32'd0);

    // Subsequent read completes normally
    sa_data = 8'h0F;
    start_op(1'b0, 2'd1, 8'h00);
    check_op("rd_after_abort", 1'b0, 1'b0, 2'd1, 8'h00, 8'h0F, RD_TOTAL + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Digital sequencer for the SRAM macro (write_driver + cell_array + sense_amp). Accepts single-word read/write requests over a valid/ready handshake and generates one-hot write/read wordline enables, write-driver data/enable, bitline precharge and sense-amp strobe with programmable pulse widths. Returns read data or write completion on a single-cycle response pulse. The mixed-signal wrapper converts its logic outputs to VDD/VSS levels.

Parameters:
ROWS, 2, number of wordlines (>=2)
COLS, 8, word width / number of columns
ADDR_W, 1, request address width (>= clog2(ROWS))
PRE_CYC, 2, precharge duration in clk cycles (>=1)
WL_CYC, 10, wordline pulse width in clk cycles (>=1)
REC_CYC, 2, wordline-low recovery time before response (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  row address
req_wdata  in  COLS  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  address out of range (valid with rsp_valid)
rsp_rdata  out  COLS  read data (valid with rsp_valid on reads)
row_wr  out  ROWS  one-hot write wordline enables
row_rd  out  ROWS  one-hot read wordline enables
wr_data  out  COLS  data to write driver
wr_en  out  1  write driver enable
pre_en  out  1  read bitline precharge
sa_en  out  1  sense-amp strobe
sa_data  in  COLS  sense-amp digital output

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0 except req_ready=1; counters cleared. Reset mid-operation aborts immediately: wordlines, wr_en, pre_en, sa_en drop to 0 the cycle after the reset edge; no response issued.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready; req_we/addr/wdata registered on accept. Inputs ignored in all other states.
- States: IDLE, WR_SETUP, WR_PULSE, PRE, RD_PULSE, SENSE, RECOVER, DONE.
- Write (accept at cycle T): WR_SETUP 1 cycle (wr_data=captured data, wr_en=1); WR_PULSE WL_CYC cycles, row_wr[addr]=1, wr_en=1; RECOVER REC_CYC cycles, all wordlines 0, wr_en=0; DONE 1 cycle, rsp_valid=1. rsp_valid at T+2+WL_CYC+REC_CYC (default T+14).
- Read: PRE PRE_CYC cycles pre_en=1; RD_PULSE WL_CYC cycles row_rd[addr]=1, pre_en=0; SENSE 1 cycle row_rd still 1, sa_en=1, sa_data captured into rsp_rdata at end of cycle; RECOVER REC_CYC; DONE. rsp_valid at T+PRE_CYC+WL_CYC+REC_CYC+2 (default T+16).
- Invariants: row_wr and row_rd each at most one-hot; never both nonzero; pre_en never overlaps row_rd; wr_en never high during read states.
- rsp_rdata holds last read value until next read completes; unchanged by writes. rsp_err=0 except in DONE.
- Out-of-range address (addr>=ROWS): no wordline, wr_en, pre_en or sa_en asserted; go directly to DONE next cycle with rsp_err=1; rsp_rdata unchanged.
- DONE -> IDLE unconditionally; next accept earliest one cycle after rsp_valid. No response backpressure.
- Counters sized for max(PRE_CYC,WL_CYC,REC_CYC); count down to 1 then advance.

Test Plan:
- Reset: hold rst 3 cycles -> req_ready=1, row_wr=row_rd=0, wr_en=pre_en=sa_en=rsp_valid=0.
- Write addr=1 data=8'hA5 at T -> wr_en T+1..T+11, row_wr=2'b10 for exactly 10 cycles T+2..T+11, rsp_valid only at T+14, rsp_err=0.
- Read addr=0, sa_data=8'h3C -> pre_en T+1..T+2, row_rd=2'b01 T+3..T+13, sa_en at T+13, rsp_valid at T+16 with rsp_rdata=8'h3C.
- Back-to-back: req_valid held high with write then read -> second accept exactly one cycle after first rsp_valid; req_ready=0 throughout busy; second request stable until accepted.
- ROWS=2, ADDR_W=2, addr=3 -> no wordline/enable activity, rsp_valid and rsp_err=1 at T+1, rsp_rdata unchanged.
- rst asserted during RD_PULSE -> row_rd=0 next cycle, no rsp_valid, req_ready=1; subsequent read completes normally.
